truth_table_checker: RTL

- Response-side counterpart to our exhaustive stimulus benches for small combinational blocks.
- Receives (input vector, DUT output) sample pairs and captures the observed truth table.
- Compares each sample against a golden truth table, counts mismatches, tracks coverage of all input combinations, and reports done/pass.
- Synthesizable, so the self-check can run on the same hardware as the combinational block under test.

---
 rtl/truth_table_checker.sv | 104 ++++++++++
 1 files changed

// File: rtl/truth_table_checker.sv
// Response-side self-check for small combinational blocks: captures the observed
// truth table from (vector, output) samples and grades it against GOLDEN.
module truth_table_checker #(
  parameter int                   N_IN   = 3,
  parameter logic [(1<<N_IN)-1:0] GOLDEN = 8'hE8,
  parameter int                   CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   vec_valid,
  input  logic [N_IN-1:0]        vec_in,
  input  logic                   q_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       err_count,
  output logic [(1<<N_IN)-1:0]   cov_mask,
  output logic [(1<<N_IN)-1:0]   cap_table,
  output logic [N_IN-1:0]        first_fail_idx,
  output logic                   first_fail_vld
);

  localparam int TBL = 1 << N_IN;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic             accept, clear, finish, mismatch;
  logic [TBL-1:0]   idx_hot, cov_upd;
  logic [CNT_W-1:0] err_upd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign idx_hot  = {{(TBL-1){1'b0}}, 1'b1} << vec_in;
  assign mismatch = (q_in != GOLDEN[vec_in]);
  assign cov_upd  = cov_mask | idx_hot;
  assign err_upd  = mismatch ? sat_inc(err_count) : err_count;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Completion is judged on the coverage the current sample produces, so done
  // rises on the same edge that registers the final sample.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    clear      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          clear      = 1'b1;
        end
      end
      RUN: begin
        if (vec_valid) begin
          accept = 1'b1;
          if (&cov_upd) begin
            state_next = DONE;
            finish     = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count      <= '0;
      cov_mask       <= '0;
      cap_table      <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
    end else if (clear) begin
      err_count      <= '0;
      cov_mask       <= '0;
      cap_table      <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
    end else if (accept) begin
      cap_table[vec_in] <= q_in;
      cov_mask          <= cov_upd;
      err_count         <= err_upd;
      if (mismatch && !first_fail_vld) begin
        first_fail_idx <= vec_in;
        first_fail_vld <= 1'b1;
      end
      if (finish) pass <= (err_upd == '0);
    end
  end

endmodule
